fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RV32I core. It issues word reads to instruction memory and waits for the response. It then drives the instruction register's load strobe and data, and holds the instruction for decode under a valid/ready handshake. It also handles control-flow redirects, including discarding an in-flight response, and keeps fetch/discard counters.

---
 rtl/rv32i_types_pkg.sv | 17 +
 rtl/fetch_ctrl_perf_cnt.sv | 31 +++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: fetch sequencer state encoding and PC helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Redirect targets are word addresses; the low two bits are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_perf_cnt.sv
// Fetch performance counters: delivered instructions and redirect discards.
// Both counters simply wrap at 2^CNT_W.
module fetch_perf_cnt
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_inc,
    input  logic             drop_inc,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] drop_count
);

    // Count one event per strobe cycle; reset clears both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            drop_count  <= '0;
        end else begin
            if (fetch_inc) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (drop_inc) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues one word read at a time, loads the
// instruction register on the response, holds it for decode, and handles
// redirects, including throwing away a response that is already in flight.
module fetch_ctrl
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0060,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_read,
    output logic [31:0]      imem_address,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output logic             ir_load,
    output logic [31:0]      ir_data,
    output logic [31:0]      inst_pc,
    output logic             inst_valid,
    input  logic             dec_ready,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] drop_count
);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  req_pc, req_pc_n;
    logic [31:0]  inst_pc_n;
    logic         inst_valid_n;
    logic         fetch_inc;
    logic         drop_inc;
    logic [31:0]  target_pc;

    assign target_pc    = word_align(redirect_pc);
    assign imem_address = req_pc;
    assign ir_data      = imem_rdata;

    // Next-state, next-register and output decode; reset masks both strobes.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        req_pc_n     = req_pc;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;
        fetch_inc    = 1'b0;
        drop_inc     = 1'b0;
        imem_read    = 1'b0;
        ir_load      = 1'b0;

        unique case (state)
            S_FETCH: begin
                imem_read = 1'b1;
                if (imem_resp && !redirect) begin
                    ir_load      = 1'b1;
                    inst_pc_n    = req_pc;
                    fetch_pc_n   = req_pc + PC_STEP;
                    inst_valid_n = 1'b1;
                    fetch_inc    = 1'b1;
                    state_n      = S_HOLD;
                end else if (imem_resp && redirect) begin
                    fetch_pc_n = target_pc;
                    req_pc_n   = target_pc;
                    drop_inc   = 1'b1;
                end else if (redirect) begin
                    fetch_pc_n = target_pc;
                    state_n    = S_DROP;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    inst_valid_n = 1'b0;
                    fetch_pc_n   = target_pc;
                    req_pc_n     = target_pc;
                    drop_inc     = 1'b1;
                    state_n      = S_FETCH;
                end else if (dec_ready) begin
                    inst_valid_n = 1'b0;
                    req_pc_n     = fetch_pc;
                    state_n      = S_FETCH;
                end
            end

            S_DROP: begin
                // The memory cannot abort, so the old address stays on the bus.
                imem_read = 1'b1;
                if (redirect) begin
                    fetch_pc_n = target_pc;
                end
                if (imem_resp) begin
                    drop_inc = 1'b1;
                    req_pc_n = redirect ? target_pc : fetch_pc;
                    state_n  = S_FETCH;
                end
            end

            default: begin
                inst_valid_n = 1'b0;
                req_pc_n     = fetch_pc;
                state_n      = S_FETCH;
            end
        endcase

        if (rst) begin
            imem_read = 1'b0;
            ir_load   = 1'b0;
        end
    end

    // State and PC registers; reset abandons any outstanding read silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            req_pc     <= req_pc_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
        end
    end

    fetch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .fetch_inc   (fetch_inc & ~rst),
        .drop_inc    (drop_inc & ~rst),
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h4000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        ir_load;
    logic [31:0] ir_data;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;
    logic [31:0] drop_count;

    int tests    = 0;
    int failures = 0;

    // Memory model state
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_lo;
    int          lat_hi;

    // Reference model: what the fetch unit is doing, in plain terms
    logic        m_holding;
    logic        m_discard;
    logic [31:0] m_req;
    logic [31:0] m_seq;
    logic [31:0] m_target;
    logic [31:0] m_inst_pc;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_drop_cnt;

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ir_load      (ir_load),
        .ir_data      (ir_data),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .dec_ready    (dec_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_count  (fetch_count),
        .drop_count   (drop_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_holding   = 1'b0;
        m_discard   = 1'b0;
        m_req       = RESET_PC;
        m_seq       = RESET_PC;
        m_target    = RESET_PC;
        m_inst_pc   = 32'h0;
        m_fetch_cnt = 32'h0;
        m_drop_cnt  = 32'h0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_addr    = 32'h0;
    endtask

    // One full clock cycle: drive, check predicted outputs, advance model.
    task automatic applyStimulus(input logic r, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        logic        exp_read;
        logic        exp_load;
        logic        resp;
        logic        seen_read;
        logic [31:0] seen_addr;
        logic [31:0] tgt;

        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        dec_ready   = rdy;
        resp        = mem_busy && (mem_cnt == 0);
        imem_resp   = resp;
        imem_rdata  = resp ? memWord(mem_addr) : 32'hDEAD_BEEF;
        tgt         = {rpc[31:2], 2'b00};
        #1;

        exp_read = !r && !m_holding;
        exp_load = exp_read && !m_discard && resp && !rd;
        checkOutput("imem_read", {31'b0, imem_read}, {31'b0, exp_read});
        checkOutput("imem_address", imem_address, m_req);
        checkOutput("ir_load", {31'b0, ir_load}, {31'b0, exp_load});
        if (exp_load) begin
            checkOutput("ir_data", ir_data, memWord(m_req));
        end
        checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, m_holding});
        checkOutput("inst_pc", inst_pc, m_inst_pc);
        checkOutput("fetch_count", fetch_count, m_fetch_cnt);
        checkOutput("drop_count", drop_count, m_drop_cnt);

        seen_read = imem_read;
        seen_addr = imem_address;
        @(posedge clk);

        if (r) begin
            modelReset();
        end else begin
            if (m_holding) begin
                if (rd) begin
                    m_drop_cnt++;
                    m_holding = 1'b0;
                    m_req     = tgt;
                end else if (rdy) begin
                    m_holding = 1'b0;
                    m_req     = m_seq;
                end
            end else if (m_discard) begin
                if (rd) m_target = tgt;
                if (resp) begin
                    m_drop_cnt++;
                    m_discard = 1'b0;
                    m_req     = m_target;
                end
            end else begin
                if (resp && !rd) begin
                    m_fetch_cnt++;
                    m_holding = 1'b1;
                    m_inst_pc = m_req;
                    m_seq     = m_req + 32'd4;
                end else if (resp && rd) begin
                    m_drop_cnt++;
                    m_req = tgt;
                end else if (rd) begin
                    m_discard = 1'b1;
                    m_target  = tgt;
                end
            end

            if (mem_busy) begin
                if (resp) mem_busy = 1'b0;
                else      mem_cnt--;
            end else if (seen_read) begin
                mem_busy = 1'b1;
                mem_addr = seen_addr;
                mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rd;
        logic        rdy;
        logic        r;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = 32'h0;
        lat_lo = 2; lat_hi = 2;
        @(posedge clk); @(posedge clk); #1;
        modelReset();

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        idle(8, 1'b1);

        idle(4, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        lat_lo = 4; lat_hi = 4;
        idle(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0003, 1'b1);
        idle(10, 1'b1);

        lat_lo = 1; lat_hi = 1;
        idle(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        idle(3, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0800, 1'b1);
        idle(4, 1'b1);

        lat_lo = 4; lat_hi = 4;
        idle(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        idle(10, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        idle(14, 1'b1);

        idle(2, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        idle(8, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            lat_lo = 1;
            lat_hi = 1 + (i / 500) % 4;
            r   = ($urandom_range(199, 0) == 0);
            rd  = ($urandom_range(7, 0) == 0);
            rdy = $urandom_range(1, 0) == 1;
            case ($urandom_range(3, 0))
                0:       rpc = 32'hFFFF_FFFC | $urandom_range(3, 0);
                1:       rpc = 32'h0000_0000 | $urandom_range(7, 0);
                default: rpc = $urandom;
            endcase
            applyStimulus(r, rd, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
